uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, SHALL set clocks per bit period (25 MHz / 217 ≈ 115200 baud).
REQ-002 Parameter HALF_BIT, default 108, SHALL set the clock count from start-bit detection to the start-bit centre sample.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the number of received-byte entries; it is a power of two, ≥2.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset; one clock, reset asynchronous and active-low.
REQ-006 RX  input  1  SHALL be the asynchronous serial line, 8N1, idle high.
REQ-007 clear  input  1  SHALL, when high at a rising edge, pop the head byte if the FIFO is non-empty and clear both error flags.
REQ-008 out  output  16  SHALL be {empty, frame_err, overrun, 5'b0, data[7:0]}.

Function
REQ-009 RX SHALL pass through a two-flop synchronizer; all decisions use the second flop (rx_s).
REQ-010 States SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-011 IDLE: on rx_s==0, go to START with bit counter cleared.
REQ-012 START: when the counter reaches HALF_BIT-1, go to DATA with counter and bit index cleared if rx_s==0; otherwise return to IDLE with no byte and no flag change (glitch rejection).
REQ-013 DATA: when the counter reaches CLKS_PER_BIT-1, sample rx_s into the shift register LSB first and reset the counter; after the 8th sample, go to STOP.
REQ-014 STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s; if 1, push the byte and go to IDLE; if 0, discard the byte, set frame_err and go to BREAK.
REQ-015 BREAK: remain until rx_s==1, then go to IDLE; no start detection while in BREAK.
REQ-016 The stop sample SHALL occur exactly HALF_BIT + 9*CLKS_PER_BIT clocks (2061 by default) after the IDLE->START transition.
REQ-017 Pushed data SHALL appear on out[7:0] and empty SHALL fall on the edge after the push.
REQ-018 A push into a full FIFO SHALL be dropped and SHALL set overrun; the existing contents SHALL be unchanged.
REQ-019 Push and pop on the same edge SHALL both take effect; when full, this SHALL NOT count as overrun.
REQ-020 With the FIFO empty, a push and clear on the same edge SHALL store the byte; the pop is ignored and the flags are cleared.
REQ-021 An error set and a clear on the same edge: the set SHALL win.
REQ-022 out[7:0] SHALL show the FIFO head when non-empty and 8'h00 when empty; out[12:8] SHALL always be 0.
REQ-023 frame_err and overrun SHALL be sticky until a clear edge or reset.
REQ-024 Bit counter width SHALL hold CLKS_PER_BIT-1; FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an occupancy count.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, counters 0, synchronizer flops 1, FIFO empty, flags 0, out = 16'h8000.
REQ-026 Reset mid-frame SHALL abandon the frame with no push; reception SHALL resume on the first falling edge after rst_n rises.

Verification
REQ-027 Reset, RX held high for 5000 clocks -> out == 16'h8000 throughout.
REQ-028 Send 0x55 at 217 clocks/bit -> out == 16'h0055 one edge after the stop sample; pulse clear -> 16'h8000.
REQ-029 RX low for 50 clocks, then high -> no byte, state back to IDLE, out stays 16'h8000.
REQ-030 Send 0xA5 with stop bit 0, hold low 500 clocks, then high -> out == 16'hC000, no byte; clear -> 16'h8000; next frame 0x12 -> 16'h0012.
REQ-031 Send 0x01..0x05 with no clear -> out == 16'h2001 after the 5th frame; four clears yield 01, 02, 03, 04, then 16'h8000.
REQ-032 rst_n pulsed low during data bit 3 of 0x3C -> out == 16'h8000 at once; a following full 0x3C frame -> 16'h003C.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer, glitch rejection,
// break handling and a small received-byte FIFO with sticky error flags.
module uart_rx #(
   parameter int CLKS_PER_BIT = 217,
   parameter int HALF_BIT     = 108,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   input  logic        clear,
   output logic [15:0] out
);

   localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int NW   = AW + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      idx, idx_n;
   logic [7:0]      sh, sh_n;
   logic            rx_meta, rx_s;
   logic            push, fe_set;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [NW-1:0]   count;
   logic            empty, full, pop, wr, ov_set;
   logic            frame_err, overrun;

   // Synchronizer resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         sh    <= sh_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      push    = 1'b0;
      fe_set  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_n = S_START;
               cnt_n   = '0;
            end
         end
         S_START: begin
            // Line must still be low at the start-bit centre, else it was a glitch.
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n = S_DATA;
                  idx_n   = '0;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               sh_n  = {rx_s, sh[7:1]};
               idx_n = idx + 3'd1;
               if (idx == 3'd7) state_n = S_STOP;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  fe_set  = 1'b1;
                  state_n = S_BREAK;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_BREAK: begin
            if (rx_s) state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign empty  = (count == '0);
   assign full   = (count == NW'(FIFO_DEPTH));
   assign pop    = clear && !empty;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign wr     = push && (!full || pop);
   assign ov_set = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= sh;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({wr, pop})
            2'b10:   count <= count + NW'(1);
            2'b01:   count <= count - NW'(1);
            default: count <= count;
         endcase
      end
   end

   // Setting an error takes priority over a clear on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= fe_set ? 1'b1 : (clear ? 1'b0 : frame_err);
         overrun   <= ov_set ? 1'b1 : (clear ? 1'b0 : overrun);
      end
   end

   assign out = {empty, frame_err, overrun, 5'b0, empty ? 8'h00 : mem[rd_ptr]};

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames plus timed corner sequences, checked
// against a byte-queue/flag model of the receiver output.
module tb_uart_rx;

   localparam int CPB   = 217;
   localparam int HB    = 108;
   localparam int DEPTH = 4;
   // two synchronizer flops plus the IDLE detection edge, then HB + 9 bit periods
   localparam int LAT   = 3 + HB + 9 * CPB;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;
   logic        clear;
   logic [15:0] out;

   int tests = 0;
   int fails = 0;

   uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .RX    (rx),
      .clear (clear),
      .out   (out)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   push_cyc = 0;
   int   nfill = 0;
   int   fall_cyc = 0;
   logic prev_empty = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_empty <= out[15];
      if (prev_empty && !out[15]) begin
         push_cyc <= cyc;
         nfill    <= nfill + 1;
      end
   end

   logic [7:0] q[$];
   logic       m_fe = 1'b0;
   logic       m_ov = 1'b0;

   function automatic logic [15:0] model_out();
      logic [7:0] head;
      head = (q.size() != 0) ? q[0] : 8'h00;
      return {q.size() == 0, m_fe, m_ov, 5'b0, head};
   endfunction

   function automatic void model_frame(input logic [7:0] d, input logic stop);
      if (!stop) m_fe = 1'b1;
      else if (q.size() < DEPTH) q.push_back(d);
      else m_ov = 1'b1;
   endfunction

   function automatic void model_clear();
      if (q.size() != 0) void'(q.pop_front());
      m_fe = 1'b0;
      m_ov = 1'b0;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; drives start, 8 data bits LSB first, then the stop
   // level for a bit period plus hold. limit>=0 abandons the frame early.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int hold, input int limit);
      logic [9:0] bits;
      int n;
      bits = {stop, d, 1'b0};
      n = 0;
      fall_cyc = cyc;
      for (int b = 0; b < 10; b++) begin
         rx = bits[b];
         for (int k = 0; k < CPB + ((b == 9) ? hold : 0); k++) begin
            if (limit >= 0 && n >= limit) return;
            @(negedge clk);
            n++;
         end
      end
      rx = 1'b1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_clear();
   endtask

   task automatic wait_nonempty(input int max);
      int n;
      n = 0;
      while (out[15] && n < max) begin
         @(negedge clk);
         n++;
      end
      check("wait_nonempty", {15'b0, out[15]}, 16'h0000);
   endtask

   // Frame whose stop-sample edge coincides with a clear pulse.
   task automatic frame_clear_at_stop(input logic [7:0] d, input logic stop);
      fork
         send_frame(d, stop, 0, -1);
         begin
            repeat (LAT - 1) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
         end
      join
   endtask

   typedef struct {
      logic [7:0]  d;
      logic        stop;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic eb;
      logic bad;
      int   n0;

      tbl[0] = '{8'h55, 1'b1, 16'h0055};
      tbl[1] = '{8'h00, 1'b1, 16'h0000};
      tbl[2] = '{8'hFF, 1'b1, 16'h00FF};
      tbl[3] = '{8'hA5, 1'b0, 16'hC000};
      tbl[4] = '{8'h12, 1'b1, 16'h0012};
      tbl[5] = '{8'h80, 1'b1, 16'h0080};

      rst_n = 1'b0;
      rx    = 1'b1;
      clear = 1'b0;
      #1;
      check("reset_async", out, 16'h8000);
      idle(5);
      check("reset_held", out, 16'h8000);
      rst_n = 1'b1;

      bad = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (out !== 16'h8000) bad = 1'b1;
      end
      check("idle_5000", {15'b0, bad}, 16'h0000);

      for (int i = 0; i < 6; i++) begin
         eb = out[15];
         send_frame(tbl[i].d, tbl[i].stop, tbl[i].stop ? 0 : 500, -1);
         idle(20);
         model_frame(tbl[i].d, tbl[i].stop);
         if (tbl[i].stop) begin
            wait_nonempty(300);
            if (eb) check("latency", 16'(push_cyc - fall_cyc), 16'(LAT));
         end
         check("vec_out", out, tbl[i].exp);
         check("vec_model", out, model_out());
         pulse_clear();
         check("vec_clear", out, 16'h8000);
      end

      n0 = nfill;
      rx = 1'b0;
      idle(50);
      rx = 1'b1;
      idle(300);
      check("glitch_out", out, 16'h8000);
      check("glitch_nopush", 16'(nfill - n0), 16'h0000);
      send_frame(8'h5A, 1'b1, 0, -1);
      idle(20);
      model_frame(8'h5A, 1'b1);
      wait_nonempty(300);
      check("after_glitch_latency", 16'(push_cyc - fall_cyc), 16'(LAT));
      check("after_glitch", out, 16'h005A);
      pulse_clear();

      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 0, -1);
         idle(20);
         model_frame(8'(i), 1'b1);
      end
      check("overrun_out", out, 16'h2001);
      check("overrun_model", out, model_out());
      for (int i = 1; i <= 4; i++) begin
         check("drain_head", {8'h00, out[7:0]}, {8'h00, 8'(i)});
         pulse_clear();
         check("drain_model", out, model_out());
      end
      check("drain_empty", out, 16'h8000);

      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 1'b1, 0, -1);
         idle(20);
         model_frame(8'(i), 1'b1);
      end
      check("full_no_ov", out, 16'h0001);
      frame_clear_at_stop(8'h05, 1'b1);
      idle(20);
      void'(q.pop_front());
      q.push_back(8'h05);
      check("full_push_pop", out, 16'h0002);
      check("full_push_pop_model", out, model_out());
      for (int i = 2; i <= 5; i++) begin
         check("drain2_head", {8'h00, out[7:0]}, {8'h00, 8'(i)});
         pulse_clear();
      end
      check("drain2_empty", out, 16'h8000);

      send_frame(8'hA5, 1'b0, 200, -1);
      idle(20);
      model_frame(8'hA5, 1'b0);
      check("fe_set", out, 16'hC000);
      frame_clear_at_stop(8'h33, 1'b1);
      idle(20);
      q.push_back(8'h33);
      m_fe = 1'b0;
      check("empty_push_clear", out, 16'h0033);
      check("empty_push_clear_model", out, model_out());
      pulse_clear();
      check("epc_drain", out, 16'h8000);

      frame_clear_at_stop(8'h44, 1'b0);
      idle(20);
      m_fe = 1'b1;
      check("set_beats_clear", out, 16'hC000);
      check("set_beats_clear_model", out, model_out());
      pulse_clear();
      check("sbc_clear", out, 16'h8000);

      send_frame(8'h3C, 1'b1, 0, 4 * CPB + 100);
      rst_n = 1'b0;
      #1;
      check("midframe_reset", out, 16'h8000);
      q.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
      rx = 1'b1;
      idle(20);
      rst_n = 1'b1;
      idle(300);
      check("post_reset_idle", out, 16'h8000);
      send_frame(8'h3C, 1'b1, 0, -1);
      idle(20);
      model_frame(8'h3C, 1'b1);
      wait_nonempty(300);
      check("post_reset_latency", 16'(push_cyc - fall_cyc), 16'(LAT));
      check("post_reset_frame", out, 16'h003C);
      check("post_reset_model", out, model_out());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
